llc_set_table: RTL
==================

# llc_set_table

In-flight set table for the LLC pipeline: records every set currently between the lookup/process stages and the update stage, hands out the 3-bit table pointer carried in the proc→update FIFO packet, and frees the entry when the update stage asserts `remove_set_from_table`. It sits directly upstream of `llc_update` and answers set-conflict lookups so the input stage can stall a request whose set is already in flight.

## Interface
- `TABLE_ENTRIES`, 8, number of in-flight slots (pointer width = 3, fixed by the FIFO packet)
- `SET_BITS`, `LLC_SET_BITS`, width of a set index

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `alloc_valid`  in  1  process stage wants to register a set
- `alloc_set`  in  SET_BITS  set being registered
- `alloc_ready`  out  1  a free slot exists
- `alloc_ptr`  out  3  slot granted, valid when `alloc_valid && alloc_ready`; copied into `table_pointer_to_remove` of the FIFO packet
- `lookup_set`  in  SET_BITS  set of the request in the input stage
- `lookup_hit`  out  1  that set is in flight, so the input stage stalls
- `remove_set_from_table`  in  1  from `llc_update`
- `table_pointer_to_remove`  in  3  from `llc_update`
- `occupancy`  out  4  number of valid entries, 0..8
- `empty`  out  1  occupancy == 0
- `err_remove_invalid`  out  1  sticky: a remove targeted an invalid slot

## Operation
- State: `valid[8]`, `set_reg[8]`, 4-bit occupancy counter, sticky error bit.
- Allocation:
  - `alloc_ptr` is the lowest-index entry with `valid==0`, taken from registered state only.
  - `alloc_ready = ~&valid`.
  - On `alloc_valid && alloc_ready`: `valid[ptr]<=1`, `set_reg[ptr]<=alloc_set`.
- Removal:
  - On `remove_set_from_table`: `valid[table_pointer_to_remove]<=0`.
  - If that entry is already invalid, there is no state change and `err_remove_invalid<=1`. It holds until reset.
- Simultaneous alloc + remove:
  - Both apply and occupancy is unchanged.
  - The freed slot is not granted in the same cycle. It becomes allocatable next cycle.
  - A full table stays `alloc_ready=0` that cycle. This is deliberate: no combinational path from `llc_update` to `alloc_ready`.
- `lookup_hit` is asserted if either of these holds:
  - some `valid[i] && set_reg[i]==lookup_set && !(remove_set_from_table && table_pointer_to_remove==i)`. The remove bypass lets a same-set request proceed in the cycle its predecessor retires.
  - `alloc_valid && alloc_ready && alloc_set==lookup_set`. This covers a same-cycle allocation.
- Upstream guarantees no duplicate set allocation. The table does not check for it.
- Occupancy: +1 on alloc only, −1 on valid remove only, unchanged on both or neither. It never wraps; the valid bits bound it to 0..8.

## Timing
- `alloc_ready`, `alloc_ptr`, `occupancy` and `empty` depend on registered state only.
- `lookup_hit` is combinational from the inputs plus state, one level of compare and OR.
- Alloc and remove take effect on the next rising edge; lookup sees them one cycle later.
- Allocate-to-earliest-remove is one cycle; a remove in the cycle after allocation is legal.
- Reset (async assert, sync deassert upstream) sets every output to its reset value:
  - `valid=0`, so `alloc_ready=1`, `alloc_ptr=0`, `lookup_hit=0` while inputs are idle
  - `occupancy=0`, `empty=1`
  - `err_remove_invalid=0`
  - `set_reg` is not reset.
- Reset mid-operation drops all entries. The FIFO and `llc_update` are reset on the same `rst`.

## Structure
- `LLC_TABLE_ENTRIES` (8) goes in `cache_consts.svh`.
- `llc_table_ptr_t` (logic [2:0]) goes in `cache_types.svh` and is reused by `fifo_proc_update_packet`.
- One sub-module, `llc_free_enc`: 8-bit lowest-zero priority encoder producing `ptr[2:0]` and `any_free`.
- CAM compare and counter are inline.

## Test plan
- After reset, alloc sets 0x10, 0x11, 0x12 on consecutive cycles: `alloc_ptr` = 0, 1, 2 and `occupancy`=3. Then `lookup_set`=0x11 gives `lookup_hit`=1, and `lookup_set`=0x20 gives 0.
- Fill 8 entries: `alloc_ready`=0. Remove ptr 5 and alloc in the same cycle: no grant that cycle, `occupancy` stays 8. Next cycle `alloc_ptr`=5 and `alloc_ready`=1.
- Set 0x33 in ptr 2, remove ptr 2 with `lookup_set`=0x33 in the same cycle: `lookup_hit`=0.
- Alloc 0x40 with `lookup_set`=0x40 in the same cycle on an empty table: `lookup_hit`=1.
- Remove ptr 7 while `valid[7]`=0: state and occupancy unchanged, `err_remove_invalid`=1 and it stays high.
- With 4 entries valid, assert `rst` low mid-cycle: outputs immediately read `occupancy`=0, `empty`=1, `alloc_ptr`=0. After release, lookup of the old sets gives 0.

Source files
------------

// File: rtl/llc_set_table_pkg.sv
// Shared constants and types for the LLC in-flight set table.
// The 3-bit table pointer type is also carried in the proc->update FIFO packet.
package llc_set_table_pkg;

  localparam int LLC_TABLE_ENTRIES = 8;
  localparam int LLC_SET_BITS      = 8;
  localparam int LLC_OCC_BITS      = 4;

  typedef logic [2:0]              llc_table_ptr_t;
  typedef logic [LLC_OCC_BITS-1:0] llc_occ_t;

endpackage

// File: rtl/llc_free_enc.sv
// Lowest-zero priority encoder over the table valid bits.
// Yields the first free slot index and whether any slot is free at all.
module llc_free_enc
  import llc_set_table_pkg::*;
(
  input  logic [LLC_TABLE_ENTRIES-1:0] valid,
  output llc_table_ptr_t               ptr,
  output logic                         any_free
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    ptr      = '0;
    any_free = 1'b0;
    for (int i = LLC_TABLE_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        ptr      = llc_table_ptr_t'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/llc_set_table.sv
// In-flight set table: grants slot pointers to the process stage, frees them on
// update-stage retirement, and flags set conflicts for the input stage.
module llc_set_table
  import llc_set_table_pkg::*;
#(
  parameter int TABLE_ENTRIES = LLC_TABLE_ENTRIES,
  parameter int SET_BITS      = LLC_SET_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [SET_BITS-1:0] alloc_set,
  output logic                alloc_ready,
  output llc_table_ptr_t      alloc_ptr,
  input  logic [SET_BITS-1:0] lookup_set,
  output logic                lookup_hit,
  input  logic                remove_set_from_table,
  input  llc_table_ptr_t      table_pointer_to_remove,
  output llc_occ_t            occupancy,
  output logic                empty,
  output logic                err_remove_invalid
);

  logic [TABLE_ENTRIES-1:0] valid;
  logic [SET_BITS-1:0]      set_reg [TABLE_ENTRIES];
  logic                     alloc_fire;
  logic                     remove_ok;

  // Grant comes from registered valid bits only, so a same-cycle remove never
  // opens a slot combinationally.
  llc_free_enc u_free_enc (
    .valid    (valid),
    .ptr      (alloc_ptr),
    .any_free (alloc_ready)
  );

  assign alloc_fire = alloc_valid && alloc_ready;
  assign remove_ok  = remove_set_from_table && valid[table_pointer_to_remove];
  assign empty      = (occupancy == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid              <= '0;
      occupancy          <= '0;
      err_remove_invalid <= 1'b0;
    end else begin
      if (remove_set_from_table) begin
        if (valid[table_pointer_to_remove]) begin
          valid[table_pointer_to_remove] <= 1'b0;
        end else begin
          err_remove_invalid <= 1'b1;
        end
      end
      // A granted slot is invalid and a valid remove targets a valid slot,
      // so the two updates never touch the same bit.
      if (alloc_fire) begin
        valid[alloc_ptr] <= 1'b1;
      end
      case ({alloc_fire, remove_ok})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      set_reg[alloc_ptr] <= alloc_set;
    end
  end

  // An entry retiring this cycle no longer blocks its set.
  always_comb begin
    lookup_hit = alloc_fire && (alloc_set == lookup_set);
    for (int i = 0; i < TABLE_ENTRIES; i++) begin
      if (valid[i] && (set_reg[i] == lookup_set) &&
          !(remove_set_from_table &&
            (table_pointer_to_remove == llc_table_ptr_t'(i)))) begin
        lookup_hit = 1'b1;
      end
    end
  end

endmodule
